// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Zero-cycle lookup for fetch, resolve/update and mispredict detection from execute.
module branch_predictor_btb #(
  parameter int PC_W  = 32,
  parameter int IDX_W = 4,
  parameter int CTR_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [PC_W-1:0]  f_pc,
  output logic             pred_hit,
  output logic             pred_taken,
  output logic [PC_W-1:0]  pred_target,
  input  logic             x_valid,
  input  logic             x_cond,
  input  logic [PC_W-1:0]  x_pc,
  input  logic             x_taken,
  input  logic [PC_W-1:0]  x_target,
  input  logic             x_pred_taken,
  input  logic [PC_W-1:0]  x_pred_target,
  output logic             mispredict,
  output logic [PC_W-1:0]  redirect_pc,
  output logic [CTR_W-1:0] cnt_branches,
  output logic [CTR_W-1:0] cnt_mispred
);
  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = PC_W - IDX_W;

  logic             entry_valid  [ENTRIES];
  logic [TAG_W-1:0] entry_tag    [ENTRIES];
  logic [PC_W-1:0]  entry_target [ENTRIES];
  logic [1:0]       entry_ctr    [ENTRIES];

  logic [IDX_W-1:0] f_idx;
  logic [IDX_W-1:0] x_idx;
  logic [TAG_W-1:0] f_tag;
  logic [TAG_W-1:0] x_tag;
  logic             x_hit;

  assign f_idx = f_pc[IDX_W-1:0];
  assign f_tag = f_pc[PC_W-1:IDX_W];
  assign x_idx = x_pc[IDX_W-1:0];
  assign x_tag = x_pc[PC_W-1:IDX_W];
  assign x_hit = entry_valid[x_idx] && (entry_tag[x_idx] == x_tag);

  // Lookup reads the registered table only, so a same-cycle update is not visible.
  assign pred_hit    = entry_valid[f_idx] && (entry_tag[f_idx] == f_tag);
  assign pred_taken  = pred_hit && entry_ctr[f_idx][1];
  assign pred_target = pred_taken ? entry_target[f_idx] : f_pc + PC_W'(1);

  // Gated by reset_n so the flush request drops the moment reset is asserted.
  assign mispredict  = reset_n && x_valid &&
                       ((x_taken != x_pred_taken) ||
                        (x_taken && (x_target != x_pred_target)));
  assign redirect_pc = x_taken ? x_target : x_pc + PC_W'(1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        entry_valid[i]  <= 1'b0;
        entry_tag[i]    <= '0;
        entry_target[i] <= '0;
        entry_ctr[i]    <= 2'b01;
      end
    end else if (x_valid) begin
      if (x_hit) begin
        if (x_cond) begin
          if (x_taken) begin
            if (entry_ctr[x_idx] != 2'b11) entry_ctr[x_idx] <= entry_ctr[x_idx] + 2'd1;
            entry_target[x_idx] <= x_target;
          end else if (entry_ctr[x_idx] != 2'b00) begin
            entry_ctr[x_idx] <= entry_ctr[x_idx] - 2'd1;
          end
        end else begin
          entry_ctr[x_idx]    <= 2'b11;
          entry_target[x_idx] <= x_target;
        end
      end else if (x_taken) begin
        // Allocate or evict whatever aliases to this index.
        entry_valid[x_idx]  <= 1'b1;
        entry_tag[x_idx]    <= x_tag;
        entry_target[x_idx] <= x_target;
        entry_ctr[x_idx]    <= x_cond ? 2'b10 : 2'b11;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_branches <= '0;
      cnt_mispred  <= '0;
    end else begin
      if (x_valid && (cnt_branches != '1)) cnt_branches <= cnt_branches + CTR_W'(1);
      if (mispredict && (cnt_mispred != '1)) cnt_mispred <= cnt_mispred + CTR_W'(1);
    end
  end

endmodule
